// File: rtl/shift_seq.sv
// shift_seq: 8-bit multi-step shift sequencer with a one-bit shift-carry register.
// Accepts a shift request in IDLE, performs 1..8 single-bit steps in SHIFT,
// pulses done for one cycle in DONE, then returns to IDLE.
// Build option: define SHIFT_SEQ_PARITY_EN to enable the parity-fill opcodes
// (100/101). Without it those opcodes are rejected like 110/111 and no parity
// logic exists.
module shift_seq (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [2:0] imm,
    input  logic [2:0] count,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       sc_out,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  data_q,  data_d;
    logic        sc_q,    sc_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [2:0]  op_q,    op_d;
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;
    logic        err_q,   err_d;
    logic        shift_in_s;

    // Opcode legality: rotate and clear modes always, parity modes only when built in.
    function automatic logic op_legal(input logic [2:0] code);
        logic ok;
        case (code)
            3'b000, 3'b001, 3'b010, 3'b011: ok = 1'b1;
`ifdef SHIFT_SEQ_PARITY_EN
            3'b100, 3'b101:                 ok = 1'b1;
`endif
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Step count encoding: 0 stands for a full 8-step operation.
    function automatic logic [3:0] steps_of(input logic [2:0] c);
        return (c == 3'd0) ? 4'd8 : {1'b0, c};
    endfunction

`ifdef SHIFT_SEQ_PARITY_EN
    // Even/odd parity of the working register (XOR reduction).
    function automatic logic parity8(input logic [7:0] v);
        return ^v;
    endfunction
`endif

    // Select the bit entering the vacated end of the working register this step.
    always_comb begin
        shift_in_s = 1'b0;
        case (op_q[2:1])
            2'b00:   shift_in_s = sc_q;
            2'b01:   shift_in_s = 1'b0;
`ifdef SHIFT_SEQ_PARITY_EN
            2'b10:   shift_in_s = parity8(data_q);
`endif
            default: shift_in_s = 1'b0;
        endcase
    end

    // Next-state, datapath and output-pulse computation for the sequencer.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sc_d    = sc_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (op_legal(imm)) begin
                        state_d = ST_SHIFT;
                        data_d  = data_in;
                        cnt_d   = steps_of(count);
                        op_d    = imm;
                        busy_d  = 1'b1;
                        // Clear-carry modes start from a zero carry.
                        if (imm[2:1] == 2'b01) begin
                            sc_d = 1'b0;
                        end else begin
                            sc_d = sc_q;
                        end
                    end else begin
                        // Rejected request: flag it, keep data and carry intact.
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (op_q[0] == 1'b0) begin
                    data_d = {data_q[6:0], shift_in_s};
                    sc_d   = data_q[7];
                end else begin
                    data_d = {shift_in_s, data_q[7:1]};
                    sc_d   = data_q[0];
                end
                cnt_d = cnt_q - 4'd1;
                // The edge that performs the last step also leaves SHIFT.
                if (cnt_q <= 4'd1) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d = ST_SHIFT;
                    busy_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State and registered-output update; synchronous reset has priority over start.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            data_q  <= 8'h00;
            sc_q    <= 1'b0;
            cnt_q   <= 4'd0;
            op_q    <= 3'b000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sc_q    <= sc_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign data_out = data_q;
    assign sc_out   = sc_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: a cycle-level behavioural model checked
// every cycle, plus hand-computed literal expectations for the directed cases.
// Honours SHIFT_SEQ_PARITY_EN the same way the design does.
module tb_shift_seq;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [2:0] imm;
    logic [2:0] count;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       sc_out;
    logic       busy;
    logic       done;
    logic       err;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

`ifdef SHIFT_SEQ_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    shift_seq dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .imm      (imm),
        .count    (count),
        .data_in  (data_in),
        .data_out (data_out),
        .sc_out   (sc_out),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Carry and data viewed as one 9-bit word {sc, data}.
    function automatic logic [8:0] m_step(input logic [8:0] cw, input logic [2:0] op);
        logic in_bit;
        int   mode;
        mode = int'(op) / 2;
        if (mode == 0)      in_bit = cw[8];
        else if (mode == 1) in_bit = 1'b0;
        else                in_bit = ^cw[7:0];
        if (op[0] == 1'b0) return {cw[7:0], in_bit};
        else               return {cw[0], in_bit, cw[7:1]};
    endfunction

    function automatic bit m_legal(input logic [2:0] op);
        return (int'(op) < 4) || (PAR && int'(op) < 6);
    endfunction

    logic [7:0] m_data;
    logic       m_sc;
    logic [2:0] m_op;
    int         m_rem;
    logic       m_done;
    logic       m_err;

    // Model update on every rising edge.
    always @(posedge clk) begin
        logic was_done;
        if (!reset_n) begin
            m_data = 8'h00; m_sc = 1'b0; m_op = 3'b000;
            m_rem = 0; m_done = 1'b0; m_err = 1'b0;
        end else begin
            was_done = m_done;
            m_done = 1'b0;
            m_err  = 1'b0;
            if (m_rem > 0) begin
                {m_sc, m_data} = m_step({m_sc, m_data}, m_op);
                m_rem = m_rem - 1;
                if (m_rem == 0) m_done = 1'b1;
            end else if (!was_done && start) begin
                if (m_legal(imm)) begin
                    m_data = data_in;
                    m_op   = imm;
                    m_rem  = (count == 3'd0) ? 8 : int'(count);
                    if (imm == 3'b010 || imm == 3'b011) m_sc = 1'b0;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_data", {24'h0, data_out}, {24'h0, m_data});
            chk("cyc_sc",   {31'h0, sc_out},   {31'h0, m_sc});
            chk("cyc_busy", {31'h0, busy},     {31'h0, (m_rem > 0)});
            chk("cyc_done", {31'h0, done},     {31'h0, m_done});
            chk("cyc_err",  {31'h0, err},      {31'h0, m_err});
            chk("busy_and_done", {31'h0, busy & done}, 32'h0);
            chk("busy_and_err",  {31'h0, busy & err},  32'h0);
        end
    end

    // ---------------- directed stimulus helpers ----------------
    // Issue one legal op; report edges from accept to done and busy cycles seen.
    task automatic run_op(input logic [2:0] i, input logic [2:0] c, input logic [7:0] d,
                          output int lat, output int bcy);
        int n;
        @(negedge clk);
        start = 1'b1; imm = i; count = c; data_in = d;
        @(negedge clk);
        start = 1'b0;
        n = 0; bcy = 0;
        while (!done && n < 20) begin
            if (busy) bcy++;
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 32'h0, 32'h1);
        lat = n;
    endtask

    // Issue one rejected op and check the err pulse and untouched state.
    task automatic run_illegal(input logic [2:0] i, input logic [7:0] ed, input logic es,
                               input string nm);
        @(negedge clk);
        start = 1'b1; imm = i; count = 3'd3; data_in = 8'hEE;
        @(negedge clk);
        start = 1'b0;
        chk({nm, "_err_hi"}, {31'h0, err},  32'h1);
        chk({nm, "_busy0"},  {31'h0, busy}, 32'h0);
        chk({nm, "_data"},   {24'h0, data_out}, {24'h0, ed});
        chk({nm, "_sc"},     {31'h0, sc_out},   {31'h0, es});
        @(negedge clk);
        chk({nm, "_err_lo"}, {31'h0, err},  32'h0);
        chk({nm, "_busy0b"}, {31'h0, busy}, 32'h0);
    endtask

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bcy, n, dcnt;
        logic [7:0] cur_d;
        logic       cur_s;
        reset_n = 1'b0; start = 1'b0; imm = 3'b000; count = 3'd0; data_in = 8'h00;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_data", {24'h0, data_out}, 32'h0);
        chk("rst_sc",   {31'h0, sc_out},   32'h0);
        chk("rst_busy", {31'h0, busy},     32'h0);
        chk("rst_done", {31'h0, done},     32'h0);
        chk("rst_err",  {31'h0, err},      32'h0);
        reset_n = 1'b1;

        // Clear-carry left, one step on 0x81.
        run_op(3'b010, 3'd1, 8'h81, lat, bcy);
        chk("clrl_data", {24'h0, data_out}, 32'h02);
        chk("clrl_sc",   {31'h0, sc_out},   32'h1);
        chk("clrl_lat",  lat, 32'd1);

        // Rotate right through carry=1, two steps on 0x00.
        run_op(3'b001, 3'd2, 8'h00, lat, bcy);
        chk("rotr_data", {24'h0, data_out}, 32'h40);
        chk("rotr_sc",   {31'h0, sc_out},   32'h0);
        chk("rotr_busy", bcy, 32'd2);

        // Rotate left, count 0 means 8 steps, on 0xA5 with carry 0.
        run_op(3'b000, 3'd0, 8'hA5, lat, bcy);
        chk("rotl8_data", {24'h0, data_out}, 32'h52);
        chk("rotl8_sc",   {31'h0, sc_out},   32'h1);
        chk("rotl8_lat",  lat, 32'd8);
        chk("rotl8_busy", bcy, 32'd8);

`ifdef SHIFT_SEQ_PARITY_EN
        run_op(3'b100, 3'd1, 8'h07, lat, bcy);
        chk("parl_data", {24'h0, data_out}, 32'h0F);
        chk("parl_sc",   {31'h0, sc_out},   32'h0);
        run_op(3'b101, 3'd3, 8'h01, lat, bcy);
        chk("parr_data", {24'h0, data_out}, 32'h60);
        chk("parr_sc",   {31'h0, sc_out},   32'h0);
        chk("parr_lat",  lat, 32'd3);
        cur_d = 8'h60; cur_s = 1'b0;
`else
        run_illegal(3'b100, 8'h52, 1'b1, "parl_off");
        run_illegal(3'b101, 8'h52, 1'b1, "parr_off");
        cur_d = 8'h52; cur_s = 1'b1;
`endif

        run_illegal(3'b110, cur_d, cur_s, "ill110");
        run_illegal(3'b111, cur_d, cur_s, "ill111");

        // Clear-carry right, 5 steps on 0xC3, with a stray start mid-shift.
        @(negedge clk);
        start = 1'b1; imm = 3'b011; count = 3'd5; data_in = 8'hC3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; imm = 3'b000; count = 3'd1; data_in = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 3;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("stray_lat",  n, 32'd5);
        chk("stray_data", {24'h0, data_out}, 32'h06);
        chk("stray_sc",   {31'h0, sc_out},   32'h0);

        // Reset during step 3 of a 5-step rotate, with start held alongside reset.
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; imm = 3'b000; count = 3'd5; data_in = 8'h3C;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_busy", {31'h0, busy}, 32'h1);
        reset_n = 1'b0; start = 1'b1; imm = 3'b010; data_in = 8'hFF;
        @(negedge clk);
        chk("abort_data", {24'h0, data_out}, 32'h0);
        chk("abort_sc",   {31'h0, sc_out},   32'h0);
        chk("abort_busy", {31'h0, busy},     32'h0);
        chk("abort_done", {31'h0, done},     32'h0);
        reset_n = 1'b1; start = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("abort_no_done", dcnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
